hamming_ecc_decoder: RTL and testbench

//  Receive-side partner of the Hamming(7,4) encoder. Takes 7-bit codewords, computes the 3-bit syndrome,

---
 rtl/hamming_ecc_pkg.sv | 30 +++
 rtl/hamming_ecc_syndrome.sv | 11 +
 rtl/hamming_ecc_decoder.sv | 101 ++++++++++
 tb/tb_hamming_ecc_decoder.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_ecc_pkg.sv
// Shared Hamming(7,4) definitions: bit positions, types, syndrome and data extraction.
// The encoder side uses the same index constants.
package hamming_ecc_pkg;

   localparam int unsigned P1_IDX = 6;
   localparam int unsigned P2_IDX = 5;
   localparam int unsigned D0_IDX = 4;
   localparam int unsigned P4_IDX = 3;
   localparam int unsigned D1_IDX = 2;
   localparam int unsigned D2_IDX = 1;
   localparam int unsigned D3_IDX = 0;

   typedef logic [6:0] codeword_t;
   typedef logic [2:0] syndrome_t;
   typedef logic [3:0] nibble_t;

   // Result is {s4,s2,s1}: the Hamming position (1..7) of a single flipped bit, or 0.
   function automatic syndrome_t calc_syndrome(codeword_t cw);
      logic s1, s2, s4;
      s1 = cw[P1_IDX] ^ cw[D0_IDX] ^ cw[D1_IDX] ^ cw[D3_IDX];
      s2 = cw[P2_IDX] ^ cw[D0_IDX] ^ cw[D2_IDX] ^ cw[D3_IDX];
      s4 = cw[P4_IDX] ^ cw[D1_IDX] ^ cw[D2_IDX] ^ cw[D3_IDX];
      return {s4, s2, s1};
   endfunction

   function automatic nibble_t extract_data(codeword_t cw);
      return {cw[D3_IDX], cw[D2_IDX], cw[D1_IDX], cw[D0_IDX]};
   endfunction

endpackage

// File: rtl/hamming_ecc_syndrome.sv
// Combinational Hamming(7,4) syndrome generator feeding the first pipeline stage.
module hamming_ecc_syndrome
   import hamming_ecc_pkg::*;
(
   input  codeword_t codeword,
   output syndrome_t syndrome
);

   assign syndrome = calc_syndrome(codeword);

endmodule

// File: rtl/hamming_ecc_decoder.sv
// Two-stage Hamming(7,4) decoder with single-bit correction and whole-pipe stall.
// Define HAMMING_ECC_STATS_EN to add the saturating corrected-error counter (cnt_clr/err_cnt).
module hamming_ecc_decoder
   import hamming_ecc_pkg::*;
`ifdef HAMMING_ECC_STATS_EN
#(
   parameter int unsigned CNT_W = 16
)
`endif
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [6:0]       in_codeword,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [3:0]       out_data,
   output logic [2:0]       out_syndrome,
   output logic             out_corrected
`ifdef HAMMING_ECC_STATS_EN
   ,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] err_cnt
`endif
);

   logic      advance;
   syndrome_t in_syn;
   codeword_t fixed_cw;

   logic      s1_valid_q;
   codeword_t s1_cw_q;
   syndrome_t s1_syn_q;

   logic      out_valid_q;
   nibble_t   out_data_q;
   syndrome_t out_syn_q;
   logic      out_corr_q;

   // Stall decision depends only on the output side so in_ready never loops back from in_valid.
   assign advance  = !out_valid_q || out_ready;
   assign in_ready = advance;

   hamming_ecc_syndrome u_syndrome (
      .codeword (in_codeword),
      .syndrome (in_syn)
   );

   // Syndrome S names Hamming position S, which lives at codeword index 7-S.
   always_comb begin
      fixed_cw = s1_cw_q;
      for (int i = 0; i < 7; i++) begin
         if (s1_syn_q == syndrome_t'(7 - i)) begin
            fixed_cw[i] = ~s1_cw_q[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_cw_q     <= '0;
         s1_syn_q    <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_syn_q   <= '0;
         out_corr_q  <= 1'b0;
      end else if (advance) begin
         s1_valid_q  <= in_valid;
         s1_cw_q     <= in_codeword;
         s1_syn_q    <= in_syn;
         out_valid_q <= s1_valid_q;
         out_data_q  <= extract_data(fixed_cw);
         out_syn_q   <= s1_syn_q;
         out_corr_q  <= (s1_syn_q != '0);
      end
   end

   assign out_valid     = out_valid_q;
   assign out_data      = out_data_q;
   assign out_syndrome  = out_syn_q;
   assign out_corrected = out_corr_q;

`ifdef HAMMING_ECC_STATS_EN
   logic [CNT_W-1:0] err_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt_q <= '0;
      end else if (cnt_clr) begin
         err_cnt_q <= '0;
      end else if (out_valid_q && out_ready && out_corr_q && !(&err_cnt_q)) begin
         err_cnt_q <= err_cnt_q + CNT_W'(1);
      end
   end

   assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_hamming_ecc_decoder.sv
// Directed bench for hamming_ecc_decoder; counter checks run when HAMMING_ECC_STATS_EN is defined.
`timescale 1ns/1ps
module tb_hamming_ecc_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] in_codeword;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic [2:0] out_syndrome;
  logic       out_corrected;
`ifdef HAMMING_ECC_STATS_EN
  logic       cnt_clr;
  logic [3:0] err_cnt;
`endif

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

`ifdef HAMMING_ECC_STATS_EN
  hamming_ecc_decoder #(.CNT_W(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_codeword   (in_codeword),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_syndrome  (out_syndrome),
    .out_corrected (out_corrected),
    .cnt_clr       (cnt_clr),
    .err_cnt       (err_cnt)
  );
`else
  hamming_ecc_decoder dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_codeword   (in_codeword),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_syndrome  (out_syndrome),
    .out_corrected (out_corrected)
  );
`endif

  function automatic logic [6:0] encode(input logic [3:0] d);
    logic p1, p2, p4;
    p1 = d[0] ^ d[1] ^ d[3];
    p2 = d[0] ^ d[2] ^ d[3];
    p4 = d[1] ^ d[2] ^ d[3];
    return {p1, p2, d[0], p4, d[1], d[2], d[3]};
  endfunction

  // e in 0..6 flips codeword bit e; e == 7 means no error.
  function automatic logic [6:0] corrupt(input logic [3:0] d, input int e);
    logic [6:0] cw;
    cw = encode(d);
    if (e < 7) cw[e] = ~cw[e];
    return cw;
  endfunction

  function automatic logic [7:0] exp_of(input logic [3:0] d, input int e);
    logic [2:0] s;
    s = (e < 7) ? 3'(7 - e) : 3'd0;
    return {d, s, (s != 3'd0)};
  endfunction

  // One clock: drive at the falling edge, observe 1ns later, queue expectations of accepted words.
  task automatic cycle(input logic v, input logic [6:0] cw, input logic rdy, input logic [7:0] exp,
                       output logic acc, output logic got, output logic [7:0] obs);
    @(negedge clk);
    in_valid    = v;
    in_codeword = cw;
    out_ready   = rdy;
    #1;
    acc = v && in_ready;
    got = out_valid && rdy;
    obs = {out_data, out_syndrome, out_corrected};
    if (acc) exp_q.push_back(exp);
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_codeword = '0;
    out_ready   = 1'b0;
`ifdef HAMMING_ECC_STATS_EN
    cnt_clr     = 1'b0;
`endif
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready);
    end
    checks++;
    if ({out_data, out_syndrome, out_corrected} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs got=%h want=00", {out_data, out_syndrome, out_corrected});
    end
`ifdef HAMMING_ECC_STATS_EN
    checks++;
    if (err_cnt !== 4'd0) begin
      errors++; $display("FAIL reset_err_cnt got=%0d want=0", err_cnt);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_clean();
    @(negedge clk);
    in_valid = 1'b1; in_codeword = 7'h55; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL clean_latency got=%b want=0", out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL clean_valid got=%b want=1", out_valid);
    end
    checks++;
    if ({out_data, out_syndrome, out_corrected} !== 8'hB0) begin
      errors++;
      $display("FAIL clean_word got=%h want=b0", {out_data, out_syndrome, out_corrected});
    end
    @(negedge clk);
  endtask

  task automatic test_single_errors();
    logic acc, got;
    logic [7:0] obs, e;
    logic [6:0] cws[2] = '{7'h54, 7'h15};
    logic [7:0] exps[2] = '{8'hBF, 8'hB3};
    for (int k = 0; k < 133; k++) begin
      if (k < 2) cycle(1'b1, cws[k], 1'b1, exps[k], acc, got, obs);
      else if (k < 130) cycle(1'b1, corrupt(4'((k - 2) / 8), (k - 2) % 8), 1'b1,
                              exp_of(4'((k - 2) / 8), (k - 2) % 8), acc, got, obs);
      else cycle(1'b0, 7'h00, 1'b1, 8'h00, acc, got, obs);
      if (got) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL sweep_extra got=%h want=none", obs);
        end else begin
          e = exp_q.pop_front();
          if (obs !== e) begin
            errors++; $display("FAIL sweep_word k=%0d got=%h want=%h", k, obs, e);
          end
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL sweep_missing got=%0d want=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_backpressure();
    logic acc, got, rdy;
    logic [7:0] obs, e, snap;
    int idx = 0, delivered = 0, cyc = 0;
    snap = '0;
    while ((delivered < 8) && (cyc < 60)) begin
      rdy = !((cyc >= 4) && (cyc < 9));
      cycle(idx < 8, corrupt(4'(idx + 3), idx % 8), rdy, exp_of(4'(idx + 3), idx % 8),
            acc, got, obs);
      if (acc) idx++;
      if (!rdy && out_valid) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++; $display("FAIL bp_in_ready cyc=%0d got=%b want=0", cyc, in_ready);
        end
        if (cyc > 4) begin
          checks++;
          if (obs !== snap) begin
            errors++; $display("FAIL bp_stable cyc=%0d got=%h want=%h", cyc, obs, snap);
          end
        end
      end
      snap = obs;
      if (got) begin
        delivered++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL bp_extra got=%h want=none", obs);
        end else begin
          e = exp_q.pop_front();
          if (obs !== e) begin
            errors++; $display("FAIL bp_word cyc=%0d got=%h want=%h", cyc, obs, e);
          end
        end
      end
      cyc++;
    end
    checks++;
    if ((delivered != 8) || (exp_q.size() != 0)) begin
      errors++; $display("FAIL bp_count got=%0d want=8", delivered);
      exp_q.delete();
    end
  endtask

  task automatic test_streaming();
    logic acc, got;
    logic [7:0] obs, e;
    logic [3:0] d;
    int er, outs = 0;
    for (int c = 0; c < 102; c++) begin
      d  = 4'($urandom);
      er = int'($urandom_range(0, 7));
      cycle(c < 100, corrupt(d, er), 1'b1, exp_of(d, er), acc, got, obs);
      if (c >= 2) begin
        checks++;
        if (out_valid !== 1'b1) begin
          errors++; $display("FAIL stream_bubble c=%0d got=%b want=1", c, out_valid);
        end
      end
      if (got) begin
        outs++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        checks++;
        if (obs !== e) begin
          errors++; $display("FAIL stream_word c=%0d got=%h want=%h", c, obs, e);
        end
      end
    end
    checks++;
    if (outs != 100) begin
      errors++; $display("FAIL stream_count got=%0d want=100", outs);
    end
    exp_q.delete();
  endtask

  task automatic test_reset_midop();
    logic acc, got;
    logic [7:0] obs;
    cycle(1'b1, encode(4'h6), 1'b1, exp_of(4'h6, 7), acc, got, obs);
    cycle(1'b1, encode(4'h9), 1'b1, exp_of(4'h9, 7), acc, got, obs);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL rst_inflight got=%b want=1", out_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_async_valid got=%b want=0", out_valid);
    end
`ifdef HAMMING_ECC_STATS_EN
    checks++;
    if (err_cnt !== 4'd0) begin
      errors++; $display("FAIL rst_err_cnt got=%0d want=0", err_cnt);
    end
`endif
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      cycle(1'b0, 7'h00, 1'b1, 8'h00, acc, got, obs);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL rst_emitted c=%0d got=%b want=0", c, out_valid);
      end
    end
    cycle(1'b1, 7'h55, 1'b1, 8'hB0, acc, got, obs);
    cycle(1'b0, 7'h00, 1'b1, 8'h00, acc, got, obs);
    checks++;
    if (got !== 1'b0) begin
      errors++; $display("FAIL rst_latency1 got=%b want=0", got);
    end
    cycle(1'b0, 7'h00, 1'b1, 8'h00, acc, got, obs);
    checks++;
    if ((got !== 1'b1) || (obs !== 8'hB0)) begin
      errors++; $display("FAIL rst_first_word got=%b/%h want=1/b0", got, obs);
    end
    exp_q.delete();
  endtask

`ifdef HAMMING_ECC_STATS_EN
  task automatic test_stats();
    logic acc, got;
    logic [7:0] obs;
    @(negedge clk); cnt_clr = 1'b1;
    @(negedge clk); cnt_clr = 1'b0;
    #1;
    checks++;
    if (err_cnt !== 4'd0) begin
      errors++; $display("FAIL stats_clear got=%0d want=0", err_cnt);
    end
    for (int i = 0; i < 23; i++) begin
      cycle(i < 20, corrupt(4'(i), i % 7), 1'b1, exp_of(4'(i), i % 7), acc, got, obs);
    end
    @(negedge clk); #1;
    checks++;
    if (err_cnt !== 4'd15) begin
      errors++; $display("FAIL stats_saturate got=%0d want=15", err_cnt);
    end
    @(negedge clk); cnt_clr = 1'b1;
    @(negedge clk); cnt_clr = 1'b0;
    cycle(1'b1, corrupt(4'h5, 2), 1'b1, 8'h00, acc, got, obs);
    repeat (3) cycle(1'b0, 7'h00, 1'b1, 8'h00, acc, got, obs);
    checks++;
    if (err_cnt !== 4'd1) begin
      errors++; $display("FAIL stats_one got=%0d want=1", err_cnt);
    end
    cycle(1'b1, corrupt(4'hA, 4), 1'b1, 8'h00, acc, got, obs);
    cycle(1'b0, 7'h00, 1'b1, 8'h00, acc, got, obs);
    cycle(1'b0, 7'h00, 1'b1, 8'h00, acc, got, obs);
    cnt_clr = 1'b1;
    checks++;
    if ((got !== 1'b1) || (out_corrected !== 1'b1)) begin
      errors++; $display("FAIL stats_handshake got=%b%b want=11", got, out_corrected);
    end
    @(negedge clk); cnt_clr = 1'b0;
    #1;
    checks++;
    if (err_cnt !== 4'd0) begin
      errors++; $display("FAIL stats_clr_wins got=%0d want=0", err_cnt);
    end
    exp_q.delete();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_clean();
    test_single_errors();
    test_backpressure();
    test_streaming();
    test_reset_midop();
`ifdef HAMMING_ECC_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
